// File: rtl/motor_drive_if.sv
// Steering command in, PWM/brake/status out, between the DIR decoder and the H-bridge pins.
// Pure wiring bundle: no latency and no backpressure.
interface motor_drive_if #(
  parameter int CW = 10
);
  logic [3:0]    DIR;
  logic          PWM_L;
  logic          PWM_R;
  logic          BRAKE;
  logic          MOVING;
  logic [CW-1:0] DUTY_L;
  logic [CW-1:0] DUTY_R;

  modport master (
    output DIR,
    input  PWM_L, PWM_R, BRAKE, MOVING, DUTY_L, DUTY_R
  );

  modport slave (
    input  DIR,
    output PWM_L, PWM_R, BRAKE, MOVING, DUTY_L, DUTY_R
  );
endinterface

// File: rtl/motor_drive.sv
// Decodes DIR into per-wheel duty, ramps at PWM period boundaries, drives PWM and timed brake.
// Latency: DIR acts 2 edges after it appears; no backpressure, the command is sampled every cycle.
module motor_drive #(
  parameter int PWM_PERIOD   = 1000,
  parameter int DUTY_SLOW    = 400,
  parameter int RAMP_STEP    = 50,
  parameter int BRAKE_CYCLES = 2_500_000
) (
  input logic          clk,
  input logic          rst,
  motor_drive_if.slave bus
);
  localparam int CW = $clog2(PWM_PERIOD + 1);
  localparam int BW = $clog2(BRAKE_CYCLES + 1);

  localparam logic [CW-1:0] FULL   = CW'(PWM_PERIOD);
  localparam logic [CW-1:0] SLOW   = CW'(DUTY_SLOW);
  localparam logic [CW-1:0] LAST   = CW'(PWM_PERIOD - 1);
  localparam logic [CW:0]   STEP_W = (CW + 1)'(RAMP_STEP);
  localparam logic [BW-1:0] BRK_LD = BW'(BRAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUN      = 2'd1,
    BRAKE_ST = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    dir_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] duty_l;
  logic [CW-1:0] duty_r;
  logic [BW-1:0] brk_cnt;

  logic          motion;
  logic [CW-1:0] tgt_l;
  logic [CW-1:0] tgt_r;
  logic          boundary;

  // Step toward target at CW+1 bits so d+STEP cannot wrap before the clamp.
  function automatic logic [CW-1:0] ramp(input logic [CW-1:0] d, input logic [CW-1:0] t);
    logic [CW:0] up;
    up = {1'b0, d} + STEP_W;
    if (d < t)
      ramp = (up > {1'b0, t}) ? t : up[CW-1:0];
    else if (d > t)
      ramp = ({1'b0, d} >= ({1'b0, t} + STEP_W)) ? (d - STEP_W[CW-1:0]) : t;
    else
      ramp = d;
  endfunction

  always_comb begin
    motion = 1'b1;
    tgt_l  = FULL;
    tgt_r  = FULL;
    case (dir_q)
      4'b0000: ;
      4'b0101: tgt_l = SLOW;
      4'b1001: tgt_r = SLOW;
      default: begin
        motion = 1'b0;
        tgt_l  = '0;
        tgt_r  = '0;
      end
    endcase
  end

  assign boundary = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= STOPPED;
      dir_q   <= '0;
      cnt     <= '0;
      duty_l  <= '0;
      duty_r  <= '0;
      brk_cnt <= '0;
    end else begin
      dir_q <= bus.DIR;
      cnt   <= boundary ? '0 : cnt + 1'b1;
      case (state)
        STOPPED: begin
          duty_l <= '0;
          duty_r <= '0;
          if (motion) state <= RUN;
        end
        RUN: begin
          // Stop is immediate and overrides any boundary ramp on the same edge.
          if (!motion) begin
            state   <= BRAKE_ST;
            duty_l  <= '0;
            duty_r  <= '0;
            brk_cnt <= BRK_LD;
          end else if (boundary) begin
            duty_l <= ramp(duty_l, tgt_l);
            duty_r <= ramp(duty_r, tgt_r);
          end
        end
        BRAKE_ST: begin
          if (brk_cnt == '0) state <= STOPPED;
          else               brk_cnt <= brk_cnt - 1'b1;
        end
        default: state <= STOPPED;
      endcase
    end
  end

  assign bus.PWM_L  = (state == RUN) && (cnt < duty_l);
  assign bus.PWM_R  = (state == RUN) && (cnt < duty_r);
  assign bus.MOVING = (state == RUN);
  assign bus.BRAKE  = (state == BRAKE_ST);
  assign bus.DUTY_L = duty_l;
  assign bus.DUTY_R = duty_r;
endmodule

// File: tb/tb_motor_drive.sv
// Directed bench for motor_drive with PWM_PERIOD=10, DUTY_SLOW=4, RAMP_STEP=4, BRAKE_CYCLES=5.
// cyc tracks edges since the last reset edge, so the PWM counter phase is cyc % 10.
module tb_motor_drive;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  motor_drive_if #(.CW(4)) bus ();

  motor_drive #(
    .PWM_PERIOD  (10),
    .DUTY_SLOW   (4),
    .RAMP_STEP   (4),
    .BRAKE_CYCLES(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_cnt(input int n);
    do tick(); while ((cyc % 10) != n);
  endtask

  task automatic test_reset();
    bus.DIR = 4'b0000;
    rst     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.PWM_L, bus.PWM_R, bus.BRAKE, bus.MOVING, bus.DUTY_L, bus.DUTY_R} !== 12'h000) begin
        failures++;
        $display("FAIL reset_outs got=%b want=0", {bus.PWM_L, bus.PWM_R, bus.BRAKE, bus.MOVING, bus.DUTY_L, bus.DUTY_R});
      end
    end
    rst = 1'b0;
    cyc = 0;
    tick();
    checks++;
    if ({bus.BRAKE, bus.DUTY_L, bus.DUTY_R} !== 9'h000) begin
      failures++;
      $display("FAIL reset_edge1 got=%b want=0", {bus.BRAKE, bus.DUTY_L, bus.DUTY_R});
    end
    tick();
    checks++;
    if ({bus.MOVING, bus.BRAKE, bus.PWM_L, bus.DUTY_L, bus.DUTY_R} !== 11'b100_0000_0000) begin
      failures++;
      $display("FAIL reset_edge2_run got=%b want=10000000000", {bus.MOVING, bus.BRAKE, bus.PWM_L, bus.DUTY_L, bus.DUTY_R});
    end
  endtask

  task automatic test_ramp_up();
    int exp_d [3] = '{4, 8, 10};
    int hi_l, hi_r;
    for (int s = 0; s < 3; s++) begin
      goto_cnt(0);
      checks++;
      if (bus.DUTY_L !== 4'(exp_d[s]) || bus.DUTY_R !== 4'(exp_d[s])) begin
        failures++;
        $display("FAIL ramp_duty%0d got=%0d/%0d want=%0d", s, bus.DUTY_L, bus.DUTY_R, exp_d[s]);
      end
      hi_l = 0;
      hi_r = 0;
      for (int i = 0; i < 10; i++) begin
        if (bus.PWM_L === 1'b1) hi_l++;
        if (bus.PWM_R === 1'b1) hi_r++;
        if (i < 9) tick();
      end
      checks++;
      if (hi_l != exp_d[s] || hi_r != exp_d[s]) begin
        failures++;
        $display("FAIL ramp_pwm_high%0d got=%0d/%0d want=%0d", s, hi_l, hi_r, exp_d[s]);
      end
    end
  endtask

  task automatic test_veer();
    int exp_l [5] = '{6, 4, 4, 8, 10};
    int exp_r [5] = '{10, 10, 10, 6, 4};
    goto_cnt(5);
    bus.DIR = 4'b0101;
    for (int s = 0; s < 5; s++) begin
      if (s == 3) begin
        goto_cnt(5);
        bus.DIR = 4'b1001;
      end
      goto_cnt(0);
      checks++;
      if (bus.DUTY_L !== 4'(exp_l[s]) || bus.DUTY_R !== 4'(exp_r[s])) begin
        failures++;
        $display("FAIL veer_step%0d got=%0d/%0d want=%0d/%0d", s, bus.DUTY_L, bus.DUTY_R, exp_l[s], exp_r[s]);
      end
    end
  endtask

  task automatic test_stop();
    int bc;
    goto_cnt(5);
    bus.DIR = 4'b0000;
    goto_cnt(0);
    goto_cnt(0);
    checks++;
    if (bus.DUTY_L !== 4'd10 || bus.DUTY_R !== 4'd10) begin
      failures++;
      $display("FAIL stop_prep_full got=%0d/%0d want=10/10", bus.DUTY_L, bus.DUTY_R);
    end
    goto_cnt(3);
    bus.DIR = 4'b1111;
    tick();
    checks++;
    if ({bus.MOVING, bus.BRAKE, bus.PWM_L, bus.DUTY_L} !== 7'b101_1010) begin
      failures++;
      $display("FAIL stop_edge1_still_run got=%b want=1011010", {bus.MOVING, bus.BRAKE, bus.PWM_L, bus.DUTY_L});
    end
    tick();
    checks++;
    if ({bus.MOVING, bus.BRAKE, bus.PWM_L, bus.PWM_R, bus.DUTY_L, bus.DUTY_R} !== 12'b0100_0000_0000) begin
      failures++;
      $display("FAIL stop_edge2_brake got=%b want=010000000000", {bus.MOVING, bus.BRAKE, bus.PWM_L, bus.PWM_R, bus.DUTY_L, bus.DUTY_R});
    end
    bus.DIR = 4'b0000;
    bc = (bus.BRAKE === 1'b1) ? 1 : 0;
    for (int b = 0; b < 20; b++) begin
      tick();
      if (bus.BRAKE !== 1'b1) break;
      bc++;
    end
    checks++;
    if (bc != 5 || bus.BRAKE !== 1'b0) begin
      failures++;
      $display("FAIL stop_brake_len got=%0d want=5", bc);
    end
    checks++;
    if (bus.MOVING !== 1'b0 || bus.DUTY_L !== 4'd0) begin
      failures++;
      $display("FAIL stop_stopped got=%b/%0d want=0/0", bus.MOVING, bus.DUTY_L);
    end
    tick();
    checks++;
    if (bus.MOVING !== 1'b1 || bus.BRAKE !== 1'b0) begin
      failures++;
      $display("FAIL stop_rerun got=%b%b want=10", bus.MOVING, bus.BRAKE);
    end
  endtask

  task automatic test_invalid();
    int bc;
    bus.DIR = 4'b0011;
    tick();
    tick();
    checks++;
    if ({bus.MOVING, bus.BRAKE, bus.DUTY_L, bus.DUTY_R} !== 10'b01_0000_0000) begin
      failures++;
      $display("FAIL invalid_brake got=%b want=0100000000", {bus.MOVING, bus.BRAKE, bus.DUTY_L, bus.DUTY_R});
    end
    bus.DIR = 4'b0110;
    bc = 1;
    for (int b = 0; b < 20; b++) begin
      tick();
      if (bus.BRAKE !== 1'b1) break;
      bc++;
    end
    checks++;
    if (bc != 5) begin
      failures++;
      $display("FAIL invalid_brake_len got=%0d want=5", bc);
    end
    repeat (3) tick();
    checks++;
    if (bus.MOVING !== 1'b0 || bus.BRAKE !== 1'b0) begin
      failures++;
      $display("FAIL invalid_stays_stopped got=%b%b want=00", bus.MOVING, bus.BRAKE);
    end
  endtask

  task automatic test_reset_mid();
    int run_seen;
    int brk_seen;
    bus.DIR  = 4'b0000;
    run_seen = 0;
    for (int b = 0; b < 10; b++) begin
      tick();
      if (bus.MOVING === 1'b1) begin
        run_seen = 1;
        break;
      end
    end
    checks++;
    if (run_seen != 1) begin
      failures++;
      $display("FAIL rstmid_run_timeout got=%0d want=1", run_seen);
    end
    bus.DIR = 4'b1111;
    tick();
    tick();
    checks++;
    if (bus.BRAKE !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_brake_entry got=%b want=1", bus.BRAKE);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.PWM_L, bus.PWM_R, bus.BRAKE, bus.MOVING, bus.DUTY_L, bus.DUTY_R} !== 12'h000) begin
      failures++;
      $display("FAIL rstmid_brake_outs got=%b want=0", {bus.PWM_L, bus.PWM_R, bus.BRAKE, bus.MOVING, bus.DUTY_L, bus.DUTY_R});
    end
    rst     = 1'b0;
    bus.DIR = 4'b0000;
    cyc     = 0;
    tick();
    tick();
    brk_seen = 0;
    checks++;
    if (bus.MOVING !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_rerun got=%b want=1", bus.MOVING);
    end
    for (int i = 0; i < 6; i++) begin
      if (bus.BRAKE !== 1'b0) brk_seen++;
      tick();
    end
    checks++;
    if (brk_seen != 0) begin
      failures++;
      $display("FAIL rstmid_residual_brake got=%0d want=0", brk_seen);
    end
    goto_cnt(0);
    goto_cnt(0);
    checks++;
    if (bus.DUTY_L !== 4'd8 || bus.DUTY_R !== 4'd8) begin
      failures++;
      $display("FAIL rstmid_partial_ramp got=%0d/%0d want=8/8", bus.DUTY_L, bus.DUTY_R);
    end
    goto_cnt(5);
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.PWM_L, bus.PWM_R, bus.BRAKE, bus.MOVING, bus.DUTY_L, bus.DUTY_R} !== 12'h000) begin
      failures++;
      $display("FAIL rstmid_ramp_outs got=%b want=0", {bus.PWM_L, bus.PWM_R, bus.BRAKE, bus.MOVING, bus.DUTY_L, bus.DUTY_R});
    end
    rst = 1'b0;
    cyc = 0;
    tick();
    tick();
    checks++;
    if ({bus.MOVING, bus.BRAKE, bus.DUTY_L, bus.DUTY_R} !== 10'b10_0000_0000) begin
      failures++;
      $display("FAIL rstmid_ramp_restart got=%b want=1000000000", {bus.MOVING, bus.BRAKE, bus.DUTY_L, bus.DUTY_R});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    bus.DIR = 4'b0000;
    test_reset();
    test_ramp_up();
    test_veer();
    test_stop();
    test_invalid();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
